// File: rtl/pad_trim_sequencer_pkg.sv
// pad_trim_pkg: shared FSM encoding, register map addresses and trim field
// layout for the pad trim sequencer.
package pad_trim_pkg;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_RAMP   = 2'd2,
      ST_SETTLE = 2'd3
   } state_e;

   // Register map
   localparam logic [3:0] ADDR_DR_TARGET = 4'd4;
   localparam logic [3:0] ADDR_DWELL     = 4'd5;
   localparam logic [3:0] ADDR_ANA       = 4'd6;

   // Per-channel trim field layout
   localparam int TRIM_W       = 3;
   localparam int TRIM_PU_BIT  = 0;
   localparam int TRIM_WPU_BIT = 1;
   localparam int TRIM_WPD_BIT = 2;

   // Clamp a requested driver count to the number of physical drivers
   function automatic logic [2:0] sat_target(input logic [2:0] req, input int max_cnt);
      if (int'(req) > max_cnt) begin
         return 3'(max_cnt);
      end
      return req;
   endfunction

endpackage

// File: rtl/pad_trim_sequencer_dr_ramp.sv
// dr_ramp: thermometer-coded driver-enable stepper. After start it moves the
// enable vector one driver at a time toward the target, one step every
// dwell+1 cycles, and stops once the target count is reached.
module dr_ramp #(
   parameter int DR_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      target,
   input  logic [7:0]      dwell,
   output logic [DR_W-1:0] dr_en,
   output logic            at_target,
   output logic            step
);
   logic [DR_W-1:0] dr_en_q, dr_en_d, tgt_mask;
   logic [7:0]      cnt_q, cnt_d;
   logic            active_q, active_d;

   // Target count expressed as the thermometer code it should settle on
   always_comb begin
      tgt_mask = '0;
      for (int i = 0; i < DR_W; i++) begin
         tgt_mask[i] = (i < int'(target));
      end
   end

   assign at_target = (dr_en_q == tgt_mask);
   assign step      = active_q && (cnt_q == 8'd0) && !at_target;
   assign dr_en     = dr_en_q;

   // Dwell countdown and single-bit step toward the target
   always_comb begin
      dr_en_d  = dr_en_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      if (start) begin
         active_d = 1'b1;
         cnt_d    = dwell;
      end else if (active_q) begin
         if (at_target) begin
            active_d = 1'b0;
         end else if (cnt_q == 8'd0) begin
            cnt_d = dwell;
            // Both vectors are thermometer codes, so unsigned order equals count order
            if (dr_en_q < tgt_mask) begin
               dr_en_d = (dr_en_q << 1) | DR_W'(1);
            end else begin
               dr_en_d = dr_en_q >> 1;
            end
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
   end

   // Ramp state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dr_en_q  <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         dr_en_q  <= dr_en_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

endmodule

// File: rtl/pad_trim_sequencer.sv
// pad_trim_sequencer: shadow registers plus a commit sequencer that drops
// ana_en, applies a trim snapshot, ramps the ckouta drivers, waits for the
// pads to settle and then restores ana_en.
//
// commit is a one-cycle request. It is accepted immediately when busy is low;
// while busy is high it is remembered in a single pending flag and serviced
// back-to-back, without busy dropping, when the current sequence finishes.
module pad_trim_sequencer
   import pad_trim_pkg::*;
#(
   parameter int NUM_CH     = 3,
   parameter int DR_W       = 5,
   parameter int SETTLE_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [7:0]        cfg_wdata,
   input  logic              commit,
   output logic              busy,
   output logic              done,
   output logic              conflict,
   output logic [NUM_CH-1:0] pu_trim,
   output logic [NUM_CH-1:0] weakpu_trim,
   output logic [NUM_CH-1:0] weakpd_trim,
   output logic [DR_W-1:0]   ckouta_dr_en,
   output logic              ana_en,
   output state_e            dbg_state
);
   localparam int            SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

   state_e                         state_q, state_d;
   logic [NUM_CH-1:0][TRIM_W-1:0]  trim_sh_q, trim_sh_d, snap_trim_q, snap_trim_d;
   logic [2:0]                     tgt_sh_q, tgt_sh_d, snap_tgt_q, snap_tgt_d;
   logic [7:0]                     dwell_sh_q, dwell_sh_d, snap_dwell_q, snap_dwell_d;
   logic                           ana_sh_q, ana_sh_d, snap_ana_q, snap_ana_d;
   logic                           pending_q, pending_d;
   logic [SW-1:0]                  settle_q, settle_d;
   logic [NUM_CH-1:0]              pu_q, pu_d, wpu_q, wpu_d, wpd_q, wpd_d;
   logic                           ana_q, ana_d, done_q, done_d, conf_q, conf_d;
   logic                           ramp_start, ramp_at_target, ramp_step;
   logic                           finish, restart, take_snap;

   dr_ramp #(.DR_W(DR_W)) u_ramp (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (ramp_start),
      .target    (snap_tgt_q),
      .dwell     (snap_dwell_q),
      .dr_en     (ckouta_dr_en),
      .at_target (ramp_at_target),
      .step      (ramp_step)
   );

   // The settle count restarts on every output change, so it expires
   // SETTLE_CYC cycles after the last change regardless of how it ended
   assign finish    = (settle_q == '0) &&
                      ((state_q == ST_SETTLE) || ((state_q == ST_RAMP) && ramp_at_target));
   assign restart   = finish && (pending_q || commit);
   assign take_snap = ((state_q == ST_IDLE) && commit) || restart;

   // Shadow register writes; the next value feeds a same-cycle snapshot
   always_comb begin
      trim_sh_d  = trim_sh_q;
      tgt_sh_d   = tgt_sh_q;
      dwell_sh_d = dwell_sh_q;
      ana_sh_d   = ana_sh_q;
      if (cfg_we) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_addr == 4'(i)) trim_sh_d[i] = cfg_wdata[TRIM_W-1:0];
         end
         if (cfg_addr == ADDR_DR_TARGET) tgt_sh_d   = sat_target(cfg_wdata[2:0], DR_W);
         if (cfg_addr == ADDR_DWELL)     dwell_sh_d = cfg_wdata;
         if (cfg_addr == ADDR_ANA)       ana_sh_d   = cfg_wdata[0];
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (commit) state_d = ST_APPLY;
         ST_APPLY:  state_d = ramp_at_target ? ST_SETTLE : ST_RAMP;
         ST_RAMP,
         ST_SETTLE: begin
            if (finish)              state_d = restart ? ST_APPLY : ST_IDLE;
            else if (ramp_at_target) state_d = ST_SETTLE;
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM decoded outputs
   always_comb begin
      ramp_start = (state_q == ST_APPLY);
      busy       = (state_q != ST_IDLE) || done_q;
      dbg_state  = state_q;
   end

   // Snapshot, pending flag, settle timer and pad-facing output values
   always_comb begin
      snap_trim_d  = snap_trim_q;
      snap_tgt_d   = snap_tgt_q;
      snap_dwell_d = snap_dwell_q;
      snap_ana_d   = snap_ana_q;
      if (take_snap) begin
         snap_trim_d  = trim_sh_d;
         snap_tgt_d   = tgt_sh_d;
         snap_dwell_d = dwell_sh_d;
         snap_ana_d   = ana_sh_d;
      end

      pending_d = pending_q;
      if (restart) pending_d = 1'b0;
      else if (commit && (state_q != ST_IDLE)) pending_d = 1'b1;

      settle_d = settle_q;
      if ((state_q == ST_APPLY) || ramp_step) settle_d = SETTLE_LOAD;
      else if (settle_q != '0) settle_d = settle_q - 1'b1;

      pu_d   = pu_q;
      wpu_d  = wpu_q;
      wpd_d  = wpd_q;
      ana_d  = ana_q;
      conf_d = 1'b0;
      done_d = finish;
      if (state_q == ST_APPLY) begin
         ana_d = 1'b0;
         // Weak pull-up wins a pull-up/pull-down clash so the pad never fights itself
         for (int i = 0; i < NUM_CH; i++) begin
            pu_d[i]  = snap_trim_q[i][TRIM_PU_BIT];
            wpu_d[i] = snap_trim_q[i][TRIM_WPU_BIT];
            wpd_d[i] = snap_trim_q[i][TRIM_WPD_BIT] & ~snap_trim_q[i][TRIM_WPU_BIT];
            conf_d   = conf_d | (snap_trim_q[i][TRIM_WPU_BIT] & snap_trim_q[i][TRIM_WPD_BIT]);
         end
      end
      if (finish) ana_d = snap_ana_q;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Shadow and snapshot registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trim_sh_q    <= '0;
         tgt_sh_q     <= '0;
         dwell_sh_q   <= '0;
         ana_sh_q     <= 1'b0;
         snap_trim_q  <= '0;
         snap_tgt_q   <= '0;
         snap_dwell_q <= '0;
         snap_ana_q   <= 1'b0;
         pending_q    <= 1'b0;
         settle_q     <= '0;
      end else begin
         trim_sh_q    <= trim_sh_d;
         tgt_sh_q     <= tgt_sh_d;
         dwell_sh_q   <= dwell_sh_d;
         ana_sh_q     <= ana_sh_d;
         snap_trim_q  <= snap_trim_d;
         snap_tgt_q   <= snap_tgt_d;
         snap_dwell_q <= snap_dwell_d;
         snap_ana_q   <= snap_ana_d;
         pending_q    <= pending_d;
         settle_q     <= settle_d;
      end
   end

   // Pad-facing output registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pu_q   <= '0;
         wpu_q  <= '0;
         wpd_q  <= '0;
         ana_q  <= 1'b0;
         done_q <= 1'b0;
         conf_q <= 1'b0;
      end else begin
         pu_q   <= pu_d;
         wpu_q  <= wpu_d;
         wpd_q  <= wpd_d;
         ana_q  <= ana_d;
         done_q <= done_d;
         conf_q <= conf_d;
      end
   end

   assign pu_trim     = pu_q;
   assign weakpu_trim = wpu_q;
   assign weakpd_trim = wpd_q;
   assign ana_en      = ana_q;
   assign done        = done_q;
   assign conflict    = conf_q;

endmodule

// File: tb/tb_pad_trim_sequencer.sv
// tb_pad_trim_sequencer: table-driven trim vectors plus hand-written commit
// sequences; a timing model predicts every output cycle of each sequence.
module tb_pad_trim_sequencer;
   import pad_trim_pkg::*;

   localparam int NUM_CH     = 3;
   localparam int DR_W       = 5;
   localparam int SETTLE_CYC = 16;
   localparam int VW         = 18;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        cfg_we    = 1'b0;
   logic [3:0]  cfg_addr  = '0;
   logic [7:0]  cfg_wdata = '0;
   logic        commit    = 1'b0;
   logic        busy, done, conflict, ana_en;
   logic [2:0]  pu_trim, weakpu_trim, weakpd_trim;
   logic [4:0]  ckouta_dr_en;
   state_e      dbg_state;

   pad_trim_sequencer #(.NUM_CH(NUM_CH), .DR_W(DR_W), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_wdata    (cfg_wdata),
      .commit       (commit),
      .busy         (busy),
      .done         (done),
      .conflict     (conflict),
      .pu_trim      (pu_trim),
      .weakpu_trim  (weakpu_trim),
      .weakpd_trim  (weakpd_trim),
      .ckouta_dr_en (ckouta_dr_en),
      .ana_en       (ana_en),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int last_done = -1;
   logic [VW-1:0] exp_q[$];
   int            exp_cyc_q[$];

   // reference model of shadow registers and current driver count
   logic [2:0] m_trim[3];
   int         m_tgt, m_dw, m_cnt;
   logic       m_req;

   typedef struct {
      logic [2:0] t0, t1, t2;
      logic [2:0] pu, wpu, wpd;
      logic       cf;
   } row_t;
   row_t rows[6];

   function automatic logic [VW-1:0] pack(input logic b, input logic d, input logic c,
                                          input logic [2:0] pu, input logic [2:0] wpu,
                                          input logic [2:0] wpd, input logic [4:0] dr,
                                          input logic a);
      return {b, d, c, pu, wpu, wpd, dr, a};
   endfunction

   function automatic logic [4:0] therm(input int n);
      logic [4:0] t;
      t = '0;
      for (int i = 0; i < 5; i++) t[i] = (i < n);
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: pop every expected output vector on its cycle
   always @(negedge clk) begin
      int c;
      logic [VW-1:0] e, act;
      act = pack(busy, done, conflict, pu_trim, weakpu_trim, weakpd_trim, ckouta_dr_en, ana_en);
      if (done) begin
         done_cnt++;
         last_done = cyc;
      end
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
         c = exp_cyc_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (c < cyc) begin
            errors++;
            $display("FAIL sb_missed: entry for cycle %0d not checked, now %0d", c, cyc);
         end else if (act !== e) begin
            errors++;
            $display("FAIL sb_cycle %0d: got b/d/c/pu/wpu/wpd/dr/ana=%b expected %b", cyc, act, e);
         end
      end
   end

   // ---------------- model ----------------
   task automatic mdl_write(input logic [3:0] a, input logic [7:0] dt);
      if (a < 4'd3) m_trim[a[1:0]] = dt[2:0];
      else if (a == 4'd4) m_tgt = (int'(dt[2:0]) > DR_W) ? DR_W : int'(dt[2:0]);
      else if (a == 4'd5) m_dw = int'(dt);
      else if (a == 4'd6) m_req = dt[0];
   endtask

   // Expected output for every cycle from T+1 to done (plus one idle cycle)
   task automatic predict(input int t, input bit restart, output int d);
      int n, k, cnt;
      logic [2:0] pu, wpu, wpd;
      logic cf;
      cf = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
         pu[ch]  = m_trim[ch][0];
         wpu[ch] = m_trim[ch][1];
         wpd[ch] = m_trim[ch][2] && !m_trim[ch][1];
         if (m_trim[ch][1] && m_trim[ch][2]) cf = 1'b1;
      end
      n = (m_tgt > m_cnt) ? m_tgt - m_cnt : m_cnt - m_tgt;
      d = t + 1 + n * (m_dw + 1) + SETTLE_CYC;
      for (int c = t + 1; c <= d; c++) begin
         k = (c - t - 1) / (m_dw + 1);
         if (k > n) k = n;
         cnt = (m_tgt > m_cnt) ? m_cnt + k : m_cnt - k;
         exp_cyc_q.push_back(c);
         exp_q.push_back(pack(1'b1, c == d, cf && (c == t + 1), pu, wpu, wpd, therm(cnt),
                              (c == d) ? m_req : 1'b0));
      end
      if (!restart) begin
         exp_cyc_q.push_back(d + 1);
         exp_q.push_back(pack(1'b0, 1'b0, 1'b0, pu, wpu, wpd, therm(m_tgt), m_req));
      end
      m_cnt = m_tgt;
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < 3; i++) m_trim[i] = '0;
      m_tgt = 0;
      m_dw  = 0;
      m_cnt = 0;
      m_req = 1'b0;
   endtask

   // ---------------- drivers ----------------
   task automatic wr(input logic [3:0] a, input logic [7:0] dt);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = dt;
      @(negedge clk);
      cfg_we = 1'b0;
      mdl_write(a, dt);
   endtask

   task automatic do_commit(output int t, input logic we, input logic [3:0] a, input logic [7:0] dt);
      @(negedge clk);
      commit = 1'b1; cfg_we = we; cfg_addr = a; cfg_wdata = dt;
      t = cyc + 1;
      if (we) mdl_write(a, dt);
      @(negedge clk);
      commit = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d entries left", exp_q.size());
         exp_q.delete();
         exp_cyc_q.delete();
      end
      @(negedge clk);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int t, d, d1, d2, dc0;
      rows[0] = '{3'b111, 3'b000, 3'b101, 3'b101, 3'b001, 3'b100, 1'b1};
      rows[1] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b010, 1'b0};
      rows[2] = '{3'b110, 3'b110, 3'b110, 3'b000, 3'b111, 3'b000, 1'b1};
      rows[3] = '{3'b000, 3'b110, 3'b000, 3'b000, 3'b010, 3'b000, 1'b1};
      rows[4] = '{3'b101, 3'b011, 3'b100, 3'b011, 3'b010, 3'b101, 1'b0};
      rows[5] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
      mdl_reset();

      // reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'(pack(busy, done, conflict, pu_trim, weakpu_trim, weakpd_trim,
                                    ckouta_dr_en, ana_en)), 32'd0);
      chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      // ramp up 0 -> 5 drivers, dwell 3
      wr(4'd0, 8'h03); wr(4'd4, 8'd5); wr(4'd5, 8'd3); wr(4'd6, 8'd1);
      do_commit(t, 1'b0, 4'd0, 8'd0);
      predict(t, 1'b0, d);
      drain();
      chk("up_done_cycle", 32'(last_done), 32'(t + 37));
      chk("up_dr_final", 32'(ckouta_dr_en), 32'b11111);
      chk("up_ana_final", 32'(ana_en), 32'd1);

      // ramp down 5 -> 2 drivers
      wr(4'd4, 8'd2);
      do_commit(t, 1'b0, 4'd0, 8'd0);
      predict(t, 1'b0, d);
      drain();
      chk("down_done_cycle", 32'(last_done), 32'(t + 29));
      chk("down_dr_final", 32'(ckouta_dr_en), 32'b00011);

      // ignored addresses, and a write in the commit cycle joins the snapshot
      wr(4'd3, 8'hff); wr(4'd7, 8'hff); wr(4'd15, 8'hff);
      do_commit(t, 1'b1, 4'd0, 8'h04);
      predict(t, 1'b0, d);
      @(negedge clk);
      chk("samecyc_wpd", 32'(weakpd_trim), 32'b001);
      chk("samecyc_pu", 32'(pu_trim), 32'b000);
      drain();

      // table of trim vectors, zero ramp steps
      for (int r = 0; r < 6; r++) begin
         wr(4'd0, {5'd0, rows[r].t0});
         wr(4'd1, {5'd0, rows[r].t1});
         wr(4'd2, {5'd0, rows[r].t2});
         do_commit(t, 1'b0, 4'd0, 8'd0);
         predict(t, 1'b0, d);
         @(negedge clk);
         chk($sformatf("row%0d_pu", r), 32'(pu_trim), 32'(rows[r].pu));
         chk($sformatf("row%0d_wpu", r), 32'(weakpu_trim), 32'(rows[r].wpu));
         chk($sformatf("row%0d_wpd", r), 32'(weakpd_trim), 32'(rows[r].wpd));
         chk($sformatf("row%0d_conflict", r), 32'(conflict), 32'(rows[r].cf));
         drain();
         chk($sformatf("row%0d_done_cycle", r), 32'(last_done), 32'(t + 1 + SETTLE_CYC));
      end

      // two commits during RAMP, with writes in between: one merged restart
      dc0 = done_cnt;
      wr(4'd4, 8'd5);
      do_commit(t, 1'b0, 4'd0, 8'd0);
      predict(t, 1'b1, d1);
      repeat (3) @(negedge clk);
      do_commit(d, 1'b0, 4'd0, 8'd0);
      wr(4'd4, 8'd1);
      wr(4'd0, 8'h01);
      do_commit(d, 1'b0, 4'd0, 8'd0);
      predict(d1, 1'b0, d2);
      drain();
      chk("pend_done_count", 32'(done_cnt - dc0), 32'd2);
      chk("pend_last_done", 32'(last_done), 32'(d2));
      chk("pend_dr_final", 32'(ckouta_dr_en), 32'b00001);

      // asynchronous reset in the middle of a ramp
      wr(4'd4, 8'd5);
      do_commit(t, 1'b0, 4'd0, 8'd0);
      predict(t, 1'b0, d);
      while (cyc < t + 6) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", 32'(pack(busy, done, conflict, pu_trim, weakpu_trim, weakpd_trim,
                                      ckouta_dr_en, ana_en)), 32'd0);
      chk("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
      exp_q.delete();
      exp_cyc_q.delete();
      mdl_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_state", 32'(dbg_state), 32'(ST_IDLE));
      do_commit(t, 1'b0, 4'd0, 8'd0);
      predict(t, 1'b0, d);
      drain();
      chk("rst_zero_done_cycle", 32'(last_done), 32'(t + 1 + SETTLE_CYC));

      // randomized configurations, including target saturation and dwell 0
      for (int i = 0; i < 5; i++) begin
         wr(4'd0, 8'($urandom_range(0, 7)));
         wr(4'd1, 8'($urandom_range(0, 7)));
         wr(4'd2, 8'($urandom_range(0, 7)));
         wr(4'd4, 8'($urandom_range(0, 7)));
         wr(4'd5, 8'($urandom_range(0, 2)));
         wr(4'd6, 8'($urandom_range(0, 1)));
         do_commit(t, 1'b0, 4'd0, 8'd0);
         predict(t, 1'b0, d);
         drain();
         chk($sformatf("rand%0d_done_cycle", i), 32'(last_done), 32'(d));
      end

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // hard stop if the sequence above never completes
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pad_trim_sequencer.md
# pad_trim_sequencer

Sequenced loader for the IO-pad trim and clock-output driver controls. Configuration writes land in shadow registers; a `commit` strobe transfers a snapshot to the pad-facing outputs in a break-before-make order:
- analog enable off;
- trim bits applied;
- clock-output drive strength ramped one driver per step;
- settle wait;
- analog enable restored.

It sits directly upstream of the pad trim/port block and drives its `pu_trim_*`, `weakpu_trim_*`, `weakpd_trim_*`, `ckouta_dr_en` and `ana_en` inputs.

## Interface
Parameters:
- `NUM_CH`, 3: number of trimmed pad channels.
- `DR_W`, 5: number of `ckouta` driver-enable bits (thermometer code).
- `SETTLE_CYC`, 16: settle cycles after the last output change before `ana_en` is restored (≥1).

Ports:
- `clk` input 1: single block clock.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `cfg_we` input 1: shadow-register write strobe.
- `cfg_addr` input 4: register address.
- `cfg_wdata` input 8: write data.
- `commit` input 1: single-cycle request to apply the shadow registers.
- `busy` output 1: sequence in progress.
- `done` output 1: one-cycle pulse when a sequence completes.
- `conflict` output 1: one-cycle pulse when a snapshot had weak pull-up and weak pull-down both set on any channel.
- `pu_trim` output NUM_CH: strong pull-up trim, bit i = channel i.
- `weakpu_trim` output NUM_CH: weak pull-up trim.
- `weakpd_trim` output NUM_CH: weak pull-down trim.
- `ckouta_dr_en` output DR_W: clock-output driver enables, always a thermometer code.
- `ana_en` output 1: analog enable.

## Operation
Register map (`cfg_we` high; write takes effect at that edge):
- addr 0..NUM_CH-1: channel trim; bit0 = pu, bit1 = weakpu, bit2 = weakpd.
- addr 4: `dr_target[2:0]`, number of enabled drivers; values >DR_W saturate to DR_W.
- addr 5: `dwell[7:0]`; each ramp step lasts dwell+1 cycles.
- addr 6: bit0 = `ana_req`.
- Any other address: ignored.

Commit and snapshot rules:
- A commit accepted in IDLE snapshots all shadow registers. A `cfg_we` in the same cycle is included in the snapshot.
- Later writes affect only the next commit.
- Conflict rule: if snapshot weakpu and weakpd are both 1 on a channel, that channel's applied weakpd is forced to 0 and `conflict` pulses at the APPLY edge.
- `commit` while busy sets a single pending flag; further commits while the flag is set are merged. At `done` with the flag set, the FSM re-snapshots (current shadow) and restarts directly in APPLY, and the flag clears.

FSM states:
- **IDLE**: `commit` → APPLY.
- **APPLY** (1 cycle):
  - `ana_en` ← 0.
  - Trim outputs ← snapshot.
  - → RAMP if `ckouta_dr_en` count ≠ target, else → SETTLE.
- **RAMP**:
  - Every dwell+1 cycles, add one enable bit (LSB side) if below target, or remove the highest set bit if above.
  - Equal to target → SETTLE.
- **SETTLE**: count SETTLE_CYC cycles, then `ana_en` ← `ana_req`, `done` pulses, → IDLE (or APPLY if pending).

## Timing
Reset and steady-state behaviour:
- Reset values: all outputs 0, all shadow registers 0, FSM IDLE, pending flag 0.
- Reset asserted mid-sequence forces every output to 0 immediately, asynchronously.

Cycle timing, with `commit` sampled at edge T:
- `busy` is 1 from after T until the `done` edge, inclusive of the `done` cycle.
- APPLY outputs change at edge T+1.
- Ramp step k (k=1..N) occurs at edge T+1+k·(dwell+1).
- Let L be the last change edge (APPLY edge or final step). `ana_en` updates and `done` pulses at L+SETTLE_CYC.
- Zero steps: `done` at T+1+SETTLE_CYC.

Other rules:
- `ckouta_dr_en` changes by at most one bit per step and never goes non-thermometer.
- `ana_en` is never 1 while trim outputs or `ckouta_dr_en` are changing.

## Structure
- Package `pad_trim_pkg`: FSM state enum, address constants (`ADDR_DR_TARGET=4`, `ADDR_DWELL=5`, `ADDR_ANA=6`), trim field bit positions.
- Sub-module `dr_ramp`: thermometer up/down stepper with dwell counter.
  - Inputs: `start`, `target`, `dwell`.
  - Outputs: `dr_en`, `at_target`.
- Register map, snapshot and FSM live in the top module.

## Test plan
- Reset, then write addr 0 = 0x03, addr 4 = 5, addr 5 = 3, addr 6 = 1, commit at T:
  - trims at T+1;
  - `ckouta_dr_en` = 00001, 00011, …, 11111 at T+5, T+9, T+13, T+17, T+21;
  - `ana_en` = 1 and `done` at T+37.
- From dr_en = 11111, write target 2, commit: 11110 → 11100 → 11000 → 00111?
  - Invalid sequence; required is 01111 → 00111 → 00011, each step dwell+1 apart.
  - Expect `ana_en` 0 from T+1 until `done`.
- Write addr 1 = 0x06, commit:
  - `weakpu_trim[1]` = 1, `weakpd_trim[1]` = 0;
  - `conflict` pulses once at T+1.
- Commit twice during RAMP with a write to addr 4 in between:
  - exactly one extra sequence runs after the first `done`, using the new target;
  - `busy` stays 1 across the restart.
- Assert `rst_n` low mid-RAMP:
  - all outputs 0 immediately;
  - after release, FSM IDLE and a commit with zero shadow yields `done` at T+1+SETTLE_CYC.
